// File: rtl/frame_pacer.sv
// Frame pacer: turns FPS-divider pulses into frame_start/frame_done handshakes, counts frames and overruns.
// Optional BUSY watchdog is compiled in with `define FRAME_PACER_WATCHDOG_EN.
module frame_pacer #(
   parameter int FRAME_CNT_W = 16,
   parameter int SKIP_MAX    = 3,
   parameter int WDOG_CYCLES = 1000000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pulse,
   input  logic                   enable,
   input  logic                   frame_done,
   output logic                   frame_start,
   output logic                   frame_busy,
   output logic [FRAME_CNT_W-1:0] frame_count,
   output logic                   overrun,
   output logic [7:0]             dropped_count,
   output logic                   stall_err,
   output logic                   wdog_timeout
);

   localparam int SKIP_W = $clog2(SKIP_MAX + 2);
   localparam logic [SKIP_W:0] SKIP_LIM = (SKIP_W + 1)'(SKIP_MAX + 1);

   if (FRAME_CNT_W < 1 || SKIP_MAX < 0 || WDOG_CYCLES < 1) begin : g_param_check
      $error("frame_pacer: FRAME_CNT_W, WDOG_CYCLES must be >= 1 and SKIP_MAX >= 0");
   end

   typedef enum logic [1:0] {IDLE, WAIT_TICK, ISSUE, BUSY} state_t;

   state_t                 state_q, state_d;
   logic [FRAME_CNT_W-1:0] count_q, count_d;
   logic [7:0]             drop_q, drop_d;
   logic [SKIP_W-1:0]      skip_q, skip_d;
   logic                   stall_q, stall_d;
   logic                   overrun_q, wdog_q;
   logic                   pulse_drop, wdog_fire, done_accept;
   logic [1:0]             drop_inc;
   logic [8:0]             drop_sum;
   logic [SKIP_W:0]        skip_sum;

   assign done_accept = (state_q == BUSY) && frame_done;

   always_comb begin
      state_d    = state_q;
      pulse_drop = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) state_d = WAIT_TICK;
         end
         WAIT_TICK: begin
            if (!enable)    state_d = IDLE;
            else if (pulse) state_d = ISSUE;
         end
         ISSUE: begin
            state_d    = BUSY;
            pulse_drop = pulse;
         end
         BUSY: begin
            if (frame_done) begin
               // A pulse coinciding with completion starts the next frame rather than dropping.
               if (!enable)    state_d = IDLE;
               else if (pulse) state_d = ISSUE;
               else            state_d = WAIT_TICK;
            end else begin
               pulse_drop = pulse;
               if (wdog_fire) state_d = enable ? WAIT_TICK : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A watchdog abort and a dropped pulse in the same cycle each count as one drop.
   always_comb begin
      drop_inc = {1'b0, pulse_drop} + {1'b0, wdog_fire};
      drop_sum = {1'b0, drop_q} + {7'b0, drop_inc};
      skip_sum = {1'b0, skip_q} + (SKIP_W + 1)'(drop_inc);
      count_d  = (state_d == ISSUE) ? count_q + 1'b1 : count_q;
      drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
      stall_d  = stall_q;
      if (done_accept) begin
         skip_d = '0;
      end else if (skip_sum >= SKIP_LIM) begin
         skip_d  = SKIP_LIM[SKIP_W-1:0];
         stall_d = 1'b1;
      end else begin
         skip_d = skip_sum[SKIP_W-1:0];
      end
   end

`ifdef FRAME_PACER_WATCHDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES) + 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

   logic [WDOG_W-1:0] wcnt_q, wcnt_d;

   // wcnt_q holds the number of completed BUSY cycles of the current frame.
   assign wdog_fire = (state_q == BUSY) && !frame_done && (wcnt_q == WDOG_LAST);

   always_comb begin
      wcnt_d = wcnt_q;
      if (state_d == ISSUE)      wcnt_d = '0;
      else if (state_q == BUSY)  wcnt_d = wcnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wcnt_q <= '0;
      else     wcnt_q <= wcnt_d;
   end
`else
   assign wdog_fire = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         drop_q    <= '0;
         skip_q    <= '0;
         stall_q   <= 1'b0;
         overrun_q <= 1'b0;
         wdog_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         drop_q    <= drop_d;
         skip_q    <= skip_d;
         stall_q   <= stall_d;
         overrun_q <= pulse_drop;
         wdog_q    <= wdog_fire;
      end
   end

   assign frame_start   = (state_q == ISSUE);
   assign frame_busy    = (state_q == ISSUE) || (state_q == BUSY);
   assign frame_count   = count_q;
   assign overrun       = overrun_q;
   assign dropped_count = drop_q;
   assign stall_err     = stall_q;
   assign wdog_timeout  = wdog_q;

endmodule

// File: tb/tb_frame_pacer.sv
// Self-checking bench for frame_pacer: directed scenarios plus randomized traffic against an
// event-level reference model (frame age, armed flag, saturating counters).
module tb_frame_pacer;
   localparam int CW   = 4;
   localparam int SKIP = 3;
   localparam int WD   = 20;
`ifdef FRAME_PACER_WATCHDOG_EN
   localparam bit WDOG_ON = 1'b1;
`else
   localparam bit WDOG_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, pulse, enable, frame_done;
   logic          frame_start, frame_busy, overrun, stall_err, wdog_timeout;
   logic [CW-1:0] frame_count;
   logic [7:0]    dropped_count;

   int checks   = 0;
   int failures = 0;

   // Reference model: m_age = -1 when no frame is open, 0 in its start cycle, b in its b-th busy cycle.
   bit m_armed;
   int m_age, m_count, m_dropped, m_skip;
   bit m_stall, m_ovr, m_wdog;

   always #5 clk = ~clk;

   frame_pacer #(.FRAME_CNT_W(CW), .SKIP_MAX(SKIP), .WDOG_CYCLES(WD)) dut (
      .clk(clk), .rst(rst), .pulse(pulse), .enable(enable), .frame_done(frame_done),
      .frame_start(frame_start), .frame_busy(frame_busy), .frame_count(frame_count),
      .overrun(overrun), .dropped_count(dropped_count), .stall_err(stall_err),
      .wdog_timeout(wdog_timeout)
   );

   task automatic model_reset();
      m_armed = 0; m_age = -1; m_count = 0; m_dropped = 0; m_skip = 0;
      m_stall = 0; m_ovr = 0; m_wdog = 0;
   endtask

   task automatic model_update(input bit p, input bit e, input bit d);
      bit issue = 0, drop = 0, wfire = 0, done_ok = 0;
      if (m_age < 0) begin
         if (!m_armed)  m_armed = e;
         else if (!e)   m_armed = 0;
         else if (p)    issue = 1;
      end else if (m_age == 0) begin
         drop  = p;
         m_age = 1;
      end else if (d) begin
         done_ok = 1; m_age = -1; m_armed = e;
         issue = e && p;
      end else begin
         drop = p;
         if (WDOG_ON && m_age == WD) begin
            wfire = 1; m_age = -1; m_armed = e;
         end else begin
            m_age++;
         end
      end
      if (issue) begin
         m_age   = 0;
         m_count = (m_count + 1) % (1 << CW);
      end
      m_dropped = (m_dropped + int'(drop) + int'(wfire) > 255) ? 255 : m_dropped + int'(drop) + int'(wfire);
      if (done_ok) m_skip = 0;
      else         m_skip = (m_skip + int'(drop) + int'(wfire) > SKIP + 1) ? SKIP + 1 : m_skip + int'(drop) + int'(wfire);
      if (m_skip > SKIP) m_stall = 1;
      m_ovr  = drop;
      m_wdog = wfire;
   endtask

   // Drive one cycle of inputs, advance the model on the edge, return 1 time unit after it.
   task automatic step(input bit p, input bit e, input bit d);
      pulse = p; enable = e; frame_done = d;
      @(posedge clk);
      model_update(p, e, d);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; pulse = 0; enable = 0; frame_done = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 0;
      step(1, 0, 1);
      checks++; if (frame_start !== 1'b0)   begin failures++; $display("FAIL reset_start got=%b exp=0", frame_start); end
      checks++; if (frame_busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", frame_busy); end
      checks++; if (frame_count !== '0)     begin failures++; $display("FAIL reset_count got=%0d exp=0", frame_count); end
      checks++; if (overrun !== 1'b0)       begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
      checks++; if (dropped_count !== 8'd0) begin failures++; $display("FAIL reset_dropped got=%0d exp=0", dropped_count); end
      checks++; if (stall_err !== 1'b0)     begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_err); end
      checks++; if (wdog_timeout !== 1'b0)  begin failures++; $display("FAIL reset_wdog got=%b exp=0", wdog_timeout); end
      $display("test_reset: outputs idle after reset");
   endtask

   // Pulse every 10 cycles, frame_done 3 cycles after frame_start; 17 frames exercise the 4-bit wrap.
   task automatic test_basic();
      step(0, 1, 0);
      for (int f = 0; f < 17; f++) begin
         for (int c = 0; c < 10; c++) begin
            step(c == 0, 1, c == 4);
            checks++;
            if (frame_start !== (c == 0)) begin
               failures++; $display("FAIL basic_start frame=%0d c=%0d got=%b exp=%b", f, c, frame_start, c == 0);
            end
            checks++;
            if (overrun !== 1'b0) begin failures++; $display("FAIL basic_overrun frame=%0d c=%0d got=%b exp=0", f, c, overrun); end
         end
         checks++;
         if (frame_count !== CW'((f + 1) % 16)) begin
            failures++; $display("FAIL basic_count frame=%0d got=%0d exp=%0d", f, frame_count, (f + 1) % 16);
         end
         $display("frame %0d issued, frame_count=%0d", f + 1, frame_count);
      end
   endtask

   task automatic test_skip();
      step(1, 1, 0);
      for (int j = 0; j < 5; j++) begin
         step(0, 1, 0);
         step(0, 1, 0);
         step(1, 1, 0);
         checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL skip_overrun drop=%0d got=%b exp=1", j + 1, overrun); end
         checks++; if (dropped_count !== 8'(j + 1)) begin failures++; $display("FAIL skip_dropped drop=%0d got=%0d exp=%0d", j + 1, dropped_count, j + 1); end
         checks++; if (stall_err !== (j >= 3)) begin failures++; $display("FAIL skip_stall drop=%0d got=%b exp=%b", j + 1, stall_err, j >= 3); end
         checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL skip_nostart drop=%0d got=%b exp=0", j + 1, frame_start); end
      end
      step(0, 1, 1);
      step(0, 1, 0);
      checks++; if (stall_err !== 1'b1) begin failures++; $display("FAIL skip_sticky got=%b exp=1", stall_err); end
      checks++; if (overrun !== 1'b0)   begin failures++; $display("FAIL skip_quiet got=%b exp=0", overrun); end
      checks++; if (frame_busy !== 1'b0) begin failures++; $display("FAIL skip_done got=%b exp=0", frame_busy); end
      $display("test_skip: dropped_count=%0d stall_err=%b", dropped_count, stall_err);
   endtask

   task automatic test_back_to_back();
      step(1, 1, 0);
      step(0, 1, 0);
      step(0, 1, 0);
      step(1, 1, 1);
      checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL b2b_start got=%b exp=1", frame_start); end
      checks++; if (overrun !== 1'b0)     begin failures++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
      checks++; if (dropped_count !== 8'd5) begin failures++; $display("FAIL b2b_dropped got=%0d exp=5", dropped_count); end
      checks++; if (frame_count !== CW'(m_count)) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", frame_count, m_count); end
      step(0, 1, 0);
      step(0, 1, 0);
      step(1, 0, 1);
      checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL b2b_disabled_start got=%b exp=0", frame_start); end
      checks++; if (frame_busy !== 1'b0)  begin failures++; $display("FAIL b2b_disabled_busy got=%b exp=0", frame_busy); end
      checks++; if (overrun !== 1'b0 || dropped_count !== 8'd5) begin
         failures++; $display("FAIL b2b_disabled_drop overrun=%b dropped=%0d exp 0/5", overrun, dropped_count);
      end
      $display("test_back_to_back: frame_count=%0d", frame_count);
   endtask

   task automatic test_enable_drop();
      step(0, 1, 0);
      step(1, 1, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      checks++; if (frame_busy !== 1'b1) begin failures++; $display("FAIL endrop_busy got=%b exp=1", frame_busy); end
      step(0, 0, 1);
      checks++; if (frame_busy !== 1'b0) begin failures++; $display("FAIL endrop_finish got=%b exp=0", frame_busy); end
      for (int j = 0; j < 3; j++) begin
         step(0, 0, 0);
         step(1, 0, 0);
         step(0, 0, 0);
         checks++; if (frame_start !== 1'b0 || overrun !== 1'b0) begin
            failures++; $display("FAIL endrop_idle j=%0d start=%b overrun=%b exp 0/0", j, frame_start, overrun);
         end
      end
      step(0, 1, 0);
      step(1, 1, 0);
      checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL endrop_resume got=%b exp=1", frame_start); end
      step(0, 1, 0);
      step(0, 1, 1);
      $display("test_enable_drop: resumed, frame_count=%0d", frame_count);
   endtask

   task automatic test_watchdog();
      int base;
      step(0, 1, 0);
      step(1, 1, 0);
      base = m_dropped;
      for (int k = 1; k <= 25; k++) begin
         step(0, 1, 0);
         checks++;
         if (wdog_timeout !== (WDOG_ON && k == WD + 1)) begin
            failures++; $display("FAIL wdog_strobe k=%0d got=%b exp=%b", k, wdog_timeout, WDOG_ON && k == WD + 1);
         end
         checks++;
         if (frame_busy !== (!WDOG_ON || k <= WD)) begin
            failures++; $display("FAIL wdog_busy k=%0d got=%b exp=%b", k, frame_busy, !WDOG_ON || k <= WD);
         end
      end
      checks++;
      if (dropped_count !== 8'(base + int'(WDOG_ON))) begin
         failures++; $display("FAIL wdog_dropped got=%0d exp=%0d", dropped_count, base + int'(WDOG_ON));
      end
      if (!WDOG_ON) step(0, 1, 1);
      step(0, 1, 0);
      step(1, 1, 0);
      checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL wdog_next_start got=%b exp=1", frame_start); end
      step(0, 1, 0);
      step(0, 1, 1);
      $display("test_watchdog: watchdog=%b dropped_count=%0d", WDOG_ON, dropped_count);
   endtask

   task automatic test_random();
      bit p, e, d, lastp;
      lastp = 0;
      for (int i = 0; i < 1500; i++) begin
         e = ($urandom_range(0, 19) != 0);
         p = !lastp && ($urandom_range(0, 5) == 0);
         d = ($urandom_range(0, 4) == 0);
         lastp = p;
         step(p, e, d);
         checks++; if (frame_start !== (m_age == 0)) begin failures++; $display("FAIL rnd_start cyc=%0d got=%b exp=%b", i, frame_start, m_age == 0); end
         checks++; if (frame_busy !== (m_age >= 0)) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, frame_busy, m_age >= 0); end
         checks++; if (frame_count !== CW'(m_count)) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, frame_count, m_count); end
         checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL rnd_overrun cyc=%0d got=%b exp=%b", i, overrun, m_ovr); end
         checks++; if (dropped_count !== 8'(m_dropped)) begin failures++; $display("FAIL rnd_dropped cyc=%0d got=%0d exp=%0d", i, dropped_count, m_dropped); end
         checks++; if (stall_err !== m_stall) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, stall_err, m_stall); end
         checks++; if (wdog_timeout !== m_wdog) begin failures++; $display("FAIL rnd_wdog cyc=%0d got=%b exp=%b", i, wdog_timeout, m_wdog); end
      end
      step(0, 1, 0);
      $display("test_random: frame_count=%0d dropped_count=%0d stall_err=%b", frame_count, dropped_count, stall_err);
   endtask

   task automatic test_reset_mid();
      step(0, 1, 1);
      step(0, 1, 1);
      step(0, 1, 0);
      step(1, 1, 0);
      step(0, 1, 0);
      checks++; if (frame_busy !== 1'b1) begin failures++; $display("FAIL rstmid_pre_busy got=%b exp=1", frame_busy); end
      #2 rst = 1;
      #1;
      model_reset();
      checks++; if ({frame_start, frame_busy, overrun, stall_err, wdog_timeout} !== 5'b0) begin
         failures++; $display("FAIL rstmid_flags got=%b exp=00000", {frame_start, frame_busy, overrun, stall_err, wdog_timeout});
      end
      checks++; if (frame_count !== '0 || dropped_count !== 8'd0) begin
         failures++; $display("FAIL rstmid_counts count=%0d dropped=%0d exp 0/0", frame_count, dropped_count);
      end
      @(posedge clk);
      #1 rst = 0;
      step(1, 1, 0);
      checks++; if (frame_start !== 1'b0 || frame_busy !== 1'b0) begin
         failures++; $display("FAIL rstmid_after start=%b busy=%b exp 0/0", frame_start, frame_busy);
      end
      $display("test_reset_mid: reset cleared all outputs");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_skip();
      test_back_to_back();
      test_enable_drop();
      test_watchdog();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
